regfile_wr_arbiter: RTL and testbench

- Shares the single regfile write port (reg_in_sel / reg_in / reg_in_we) among NREQ producers, e.g. ALU writeback, memory load return and interrupt/pop logic.
- Each producer gets a 1-entry input buffer with a valid/ready handshake.
- A round-robin arbiter drains the buffers into a registered write stage that drives the regfile write port directly.
- A pending-write scoreboard mask lets decode stall reads of registers that still have a write in flight.

---
 rtl/regfile_pkg.sv | 12 +
 rtl/regfile_wr_arbiter_if.sv | 34 +++
 rtl/rr_arbiter.sv | 51 +++++
 rtl/regfile_wr_arbiter.sv | 92 +++++++++
 tb/tb_regfile_wr_arbiter.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file constants and types used by the regfile, decode and the
// write-port arbiter.
package regfile_pkg;

    localparam int REG_COUNT  = 16;
    localparam int REG_IDX_W  = 4;
    localparam int REG_DATA_W = 16;

    typedef logic [REG_IDX_W-1:0]  reg_idx_t;
    typedef logic [REG_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// Producer-side write requests plus the regfile write port, scoreboard mask
// and arbiter pointer (rr_ptr, for observation) of regfile_wr_arbiter.
interface regfile_wr_arbiter_if import regfile_pkg::*; #(
    parameter int NREQ = 3,
    parameter int RW   = REG_IDX_W,
    parameter int DW   = REG_DATA_W
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Handshake: requester i transfers on a rising edge where req_valid[i] and
    // req_ready[i] are both 1; req_ready never depends on req_valid.
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*RW-1:0] req_sel;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;

    logic               reg_in_we;
    logic [RW-1:0]      reg_in_sel;
    logic [DW-1:0]      reg_in;
    logic [2**RW-1:0]   pend_mask;
    logic               busy;
    logic [PW-1:0]      rr_ptr;

    modport master (
        output req_valid, req_sel, req_data,
        input  req_ready, reg_in_we, reg_in_sel, reg_in, pend_mask, busy, rr_ptr
    );

    modport slave (
        input  req_valid, req_sel, req_data,
        output req_ready, reg_in_we, reg_in_sel, reg_in, pend_mask, busy, rr_ptr
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational arbiter: round robin from ptr, or fixed lowest-index priority
// when REGFILE_ARB_FIXED_PRIO_EN is defined (ptr then ignored).
module rr_arbiter #(
    parameter int NREQ = 3,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [PW-1:0]   gnt_idx,
    output logic            gnt_valid
);

`ifdef REGFILE_ARB_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    // Descending scan so the lowest full index is the last to overwrite.
    always_comb begin
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[k]) begin
                gnt_idx   = PW'(k);
                gnt_valid = 1'b1;
            end
        end
    end
`else
    function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) s = s - NREQ;
        return PW'(s);
    endfunction

    always_comb begin
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!gnt_valid && req[wrap_idx(ptr, k)]) begin
                gnt_idx   = wrap_idx(ptr, k);
                gnt_valid = 1'b1;
            end
        end
    end
`endif

    assign gnt = gnt_valid ? (NREQ'(1) << gnt_idx) : '0;

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the regfile write port among NREQ producers via 1-entry buffers and a
// registered write stage. REGFILE_ARB_FIXED_PRIO_EN selects fixed priority.
module regfile_wr_arbiter import regfile_pkg::*; #(
    parameter int NREQ = 3,
    parameter int RW   = REG_IDX_W,
    parameter int DW   = REG_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    regfile_wr_arbiter_if.slave bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]  full;
    logic [NREQ-1:0]  gnt;
    logic [RW-1:0]    buf_sel  [NREQ];
    logic [DW-1:0]    buf_data [NREQ];
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    gnt_idx;
    logic             gnt_valid;
    logic             we_q;
    logic [RW-1:0]    sel_q;
    logic [DW-1:0]    data_q;
    logic [2**RW-1:0] pend;

    rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
        .req       (full),
        .ptr       (ptr),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    // A granted buffer cannot refill on the same edge: its ready was low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full   <= '0;
            we_q   <= 1'b0;
            sel_q  <= '0;
            data_q <= '0;
            for (int i = 0; i < NREQ; i++) begin
                buf_sel[i]  <= '0;
                buf_data[i] <= '0;
            end
        end else begin
            we_q <= gnt_valid;
            if (gnt_valid) begin
                sel_q  <= buf_sel[gnt_idx];
                data_q <= buf_data[gnt_idx];
            end
            for (int i = 0; i < NREQ; i++) begin
                if (gnt[i]) begin
                    full[i] <= 1'b0;
                end else if (bus.req_valid[i] && !full[i]) begin
                    full[i]     <= 1'b1;
                    buf_sel[i]  <= bus.req_sel[i*RW +: RW];
                    buf_data[i] <= bus.req_data[i*DW +: DW];
                end
            end
        end
    end

`ifdef REGFILE_ARB_FIXED_PRIO_EN
    assign ptr = '0;
`else
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (gnt_valid) begin
            ptr <= (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end
`endif

    always_comb begin
        pend = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (full[i]) pend[buf_sel[i]] = 1'b1;
        end
        if (we_q) pend[sel_q] = 1'b1;
    end

    assign bus.req_ready  = {NREQ{rst_n}} & ~full;
    // Gated so a staged write is dropped when reset lands on its commit edge.
    assign bus.reg_in_we  = we_q & rst_n;
    assign bus.reg_in_sel = sel_q;
    assign bus.reg_in     = data_q;
    assign bus.pend_mask  = pend;
    assign bus.busy       = (|full) | we_q;
    assign bus.rr_ptr     = ptr;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: handshake, latency, arbitration order,
// scoreboard mask and mid-operation reset, with a write-order scoreboard.
module tb_regfile_wr_arbiter;
    import regfile_pkg::*;

    localparam int NREQ = 3;
    localparam int RW   = 4;
    localparam int DW   = 16;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    logic [RW+DW-1:0] exp_q [$];
    logic [RW+DW-1:0] exp_w;
    logic [DW-1:0]    rf [16] = '{default: 16'h0};

    regfile_wr_arbiter_if #(.NREQ(NREQ), .RW(RW), .DW(DW)) bus ();

    regfile_wr_arbiter #(.NREQ(NREQ), .RW(RW), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.req_valid = '0;
        tick();
        rst_n = 1'b1;
    endtask

    // driver
    task automatic set_req(input int i, input logic [RW-1:0] sel, input logic [DW-1:0] data);
        bus.req_sel[i*RW +: RW]  = sel;
        bus.req_data[i*DW +: DW] = data;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // reference regfile fed by the write port
    always @(posedge clk) begin
        if (bus.reg_in_we) rf[bus.reg_in_sel] <= bus.reg_in;
    end

    // scoreboard: every regfile write must match the next expected write
    always @(negedge clk) begin
        if (bus.reg_in_we) begin
            check("wr_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                exp_w = exp_q.pop_front();
                check("wr_sel_data", 32'({bus.reg_in_sel, bus.reg_in}), 32'(exp_w));
            end
        end
    end

    initial begin
        n_cmp         = 0;
        n_bad         = 0;
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_sel   = '0;
        bus.req_data  = '0;

        // reset with all requesters valid
        bus.req_valid = 3'b111;
        tick();
        tick();
        check("rst_ready", 32'(bus.req_ready), 32'd0);
        check("rst_we", 32'(bus.reg_in_we), 32'd0);
        check("rst_pend", 32'(bus.pend_mask), 32'd0);
        bus.req_valid = '0;
        rst_n         = 1'b1;
        #1;
        check("rel_ready", 32'(bus.req_ready), 32'b111);
        check("rel_ptr", 32'(bus.rr_ptr), 32'd0);

        // single write, requester 0
        set_req(0, 4'd5, 16'hBEEF);
        exp_q.push_back({4'd5, 16'hBEEF});
        bus.req_valid = 3'b001;
        tick();
        bus.req_valid = '0;
        check("one_ready", 32'(bus.req_ready), 32'b110);
        check("one_pend_buf", 32'(bus.pend_mask), 32'h0020);
        check("one_we_early", 32'(bus.reg_in_we), 32'd0);
        tick();
        check("one_we", 32'(bus.reg_in_we), 32'd1);
        check("one_sel", 32'(bus.reg_in_sel), 32'd5);
        check("one_data", 32'(bus.reg_in), 32'hBEEF);
        check("one_pend_stage", 32'(bus.pend_mask), 32'h0020);
        tick();
        check("one_we_done", 32'(bus.reg_in_we), 32'd0);
        check("one_pend_done", 32'(bus.pend_mask), 32'd0);
        check("one_busy_done", 32'(bus.busy), 32'd0);
        check("one_rf5", 32'(rf[5]), 32'hBEEF);
`ifdef REGFILE_ARB_FIXED_PRIO_EN
        check("one_ptr", 32'(bus.rr_ptr), 32'd0);
`else
        check("one_ptr", 32'(bus.rr_ptr), 32'd1);
`endif

        // all three accepted together from ptr 0
        do_reset();
        set_req(0, 4'd1, 16'h1111);
        set_req(1, 4'd2, 16'h2222);
        set_req(2, 4'd3, 16'h3333);
        exp_q.push_back({4'd1, 16'h1111});
        exp_q.push_back({4'd2, 16'h2222});
        exp_q.push_back({4'd3, 16'h3333});
        bus.req_valid = 3'b111;
        tick();
        bus.req_valid = '0;
        check("all_ready", 32'(bus.req_ready), 32'd0);
        check("all_pend", 32'(bus.pend_mask), 32'h000E);
        check("all_busy", 32'(bus.busy), 32'd1);
        tick();
        check("all_ready_g0", 32'(bus.req_ready), 32'b001);
        tick();
        check("all_ready_g1", 32'(bus.req_ready), 32'b011);
        tick();
        check("all_sel_g2", 32'(bus.reg_in_sel), 32'd3);
        check("all_ptr", 32'(bus.rr_ptr), 32'd0);
        tick();
        check("all_busy_done", 32'(bus.busy), 32'd0);
        check("all_pend_done", 32'(bus.pend_mask), 32'd0);

        // requesters 0 and 2 streaming
        do_reset();
        set_req(0, 4'd4, 16'h0404);
        set_req(2, 4'd6, 16'h0606);
        exp_q.push_back({4'd4, 16'h0404});
        exp_q.push_back({4'd6, 16'h0606});
        exp_q.push_back({4'd4, 16'h0404});
        exp_q.push_back({4'd6, 16'h0606});
        exp_q.push_back({4'd4, 16'h0404});
        bus.req_valid = 3'b101;
        tick();
        check("alt_ready0", 32'(bus.req_ready), 32'b010);
        tick();
        check("alt_ready1", 32'(bus.req_ready), 32'b011);
        check("alt_sel1", 32'(bus.reg_in_sel), 32'd4);
        tick();
        check("alt_ready2", 32'(bus.req_ready), 32'b110);
        check("alt_sel2", 32'(bus.reg_in_sel), 32'd6);
        tick();
        check("alt_ready3", 32'(bus.req_ready), 32'b011);
        check("alt_sel3", 32'(bus.reg_in_sel), 32'd4);
        tick();
        check("alt_ready4", 32'(bus.req_ready), 32'b110);
        check("alt_sel4", 32'(bus.reg_in_sel), 32'd6);
        bus.req_valid = '0;
        tick();
        check("alt_we5", 32'(bus.reg_in_we), 32'd1);
        check("alt_sel5", 32'(bus.reg_in_sel), 32'd4);
        tick();
        check("alt_busy_done", 32'(bus.busy), 32'd0);

        // same-register conflict, pointer first moved to 2 by a req1 write
        do_reset();
        set_req(1, 4'd9, 16'h0909);
        exp_q.push_back({4'd9, 16'h0909});
        bus.req_valid = 3'b010;
        tick();
        bus.req_valid = '0;
        tick();
        tick();
        check("cf_busy_idle", 32'(bus.busy), 32'd0);
`ifdef REGFILE_ARB_FIXED_PRIO_EN
        check("cf_ptr", 32'(bus.rr_ptr), 32'd0);
`else
        check("cf_ptr", 32'(bus.rr_ptr), 32'd2);
`endif
        set_req(1, 4'd7, 16'hAAAA);
        set_req(2, 4'd7, 16'h5555);
`ifdef REGFILE_ARB_FIXED_PRIO_EN
        exp_q.push_back({4'd7, 16'hAAAA});
        exp_q.push_back({4'd7, 16'h5555});
`else
        exp_q.push_back({4'd7, 16'h5555});
        exp_q.push_back({4'd7, 16'hAAAA});
`endif
        bus.req_valid = 3'b110;
        tick();
        bus.req_valid = '0;
        check("cf_pend_buf", 32'(bus.pend_mask), 32'h0080);
        tick();
        check("cf_pend_first", 32'(bus.pend_mask), 32'h0080);
        tick();
        check("cf_pend_second", 32'(bus.pend_mask), 32'h0080);
        tick();
        check("cf_pend_done", 32'(bus.pend_mask), 32'd0);
`ifdef REGFILE_ARB_FIXED_PRIO_EN
        check("cf_rf7", 32'(rf[7]), 32'h5555);
`else
        check("cf_rf7", 32'(rf[7]), 32'hAAAA);
`endif

        // reset while buffers and write stage are occupied
        do_reset();
        set_req(0, 4'd10, 16'hA0A0);
        set_req(1, 4'd11, 16'hB1B1);
        set_req(2, 4'd12, 16'hC2C2);
        bus.req_valid = 3'b111;
        tick();
        bus.req_valid = '0;
        tick();
        check("mr_we_staged", 32'(bus.reg_in_we), 32'd1);
        check("mr_sel_staged", 32'(bus.reg_in_sel), 32'd10);
        rst_n = 1'b0;
        tick();
        check("mr_ready", 32'(bus.req_ready), 32'd0);
        check("mr_we", 32'(bus.reg_in_we), 32'd0);
        rst_n = 1'b1;
        #1;
        check("mr_pend", 32'(bus.pend_mask), 32'd0);
        check("mr_busy", 32'(bus.busy), 32'd0);
        check("mr_ready_rel", 32'(bus.req_ready), 32'b111);
        check("mr_rf10", 32'(rf[10]), 32'd0);
        tick();
        check("mr_no_write", 32'(bus.reg_in_we), 32'd0);

        tick();
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
